// File: rtl/wb_pipe_pkg.sv
// Shared types for the memory-to-writeback pipeline register.
// Optional perf counters are enabled with the WB_PIPE_PERF_EN macro (see wb_pipe_reg).
package wb_pipe_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int RD_W_DEF   = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] dm_addr;
        logic [DATA_W_DEF-1:0] alu_res;
        logic [DATA_W_DEF-1:0] dm_out;
        logic [RD_W_DEF-1:0]   rd;
        logic                  reg_w;
        logic                  mem2r;
        logic [DATA_W_DEF-1:0] wb_data;
    } wb_entry_t;

endpackage

// File: rtl/wb_pipe_slot.sv
// One valid-tagged entry register; load wins over clear so a pop and refill can share a cycle.
// Latency 1 cycle; no flow control of its own.
module wb_pipe_slot
    import wb_pipe_pkg::*;
#(
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   clear,
    input  entry_t d,
    output entry_t q,
    output logic   valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_pipe_reg.sv
// Memory-to-writeback pipeline register: 2-entry skid, 1-cycle latency, registered in_ready (= skid empty).
// Optional WB_PIPE_PERF_EN adds saturating stall/bubble counters.
module wb_pipe_reg
    import wb_pipe_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] dm_out,
    input  logic [RD_W-1:0]   rd,
    input  logic              reg_w,
    input  logic              mem2r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_dm_addr,
    output logic [DATA_W-1:0] out_dm_out,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_reg_w,
    output logic              out_mem2r,
    output logic [DATA_W-1:0] out_wb_data
`ifdef WB_PIPE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    // alu_res is only ever observed through wb_data, so it is folded in at write time.
    typedef struct packed {
        logic [ADDR_W-1:0] dm_addr;
        logic [DATA_W-1:0] dm_out;
        logic [RD_W-1:0]   rd;
        logic              reg_w;
        logic              mem2r;
        logic [DATA_W-1:0] wb_data;
    } entry_t;

    wb_state_t state;
    entry_t    in_entry, main_d, main_q, skid_q;
    logic      main_vld, skid_vld;
    logic      main_load, main_clear, skid_load, skid_clear;
    logic      accept, pop;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_comb begin
        in_entry         = '0;
        in_entry.dm_addr = dm_addr;
        in_entry.dm_out  = dm_out;
        in_entry.rd      = rd;
        in_entry.reg_w   = reg_w;
        in_entry.mem2r   = mem2r;
        in_entry.wb_data = mem2r ? dm_out : alu_res;
    end

    always_comb begin
        main_load  = 1'b0;
        main_clear = flush;
        skid_load  = 1'b0;
        skid_clear = flush;
        main_d     = in_entry;
        if (!flush) begin
            case (state)
                EMPTY: main_load = accept;
                ONE: begin
                    main_load  = accept && pop;
                    skid_load  = accept && !pop;
                    main_clear = pop && !accept;
                end
                TWO: begin
                    main_d     = skid_q;
                    main_load  = pop;
                    skid_clear = pop;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (accept) state <= ONE;
                ONE: begin
                    if (accept && !pop) begin
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (!accept && pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    wb_pipe_slot #(.entry_t(entry_t)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .q     (main_q),
        .valid (main_vld)
    );

    wb_pipe_slot #(.entry_t(entry_t)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_entry),
        .q     (skid_q),
        .valid (skid_vld)
    );

    // Data fields keep their last value in a bubble; only the write-side controls are gated.
    assign out_valid   = main_vld;
    assign out_dm_addr = main_q.dm_addr;
    assign out_dm_out  = main_q.dm_out;
    assign out_rd      = main_q.rd;
    assign out_mem2r   = main_q.mem2r;
    assign out_reg_w   = main_vld && main_q.reg_w;
    assign out_wb_data = main_vld ? main_q.wb_data : '0;

`ifdef WB_PIPE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (!out_valid && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

    logic unused_ok;
    assign unused_ok = skid_vld;

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Bench for wb_pipe_reg: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [9:0]  dm_addr;
    logic [31:0] alu_res, dm_out;
    logic [4:0]  rd;
    logic        reg_w, mem2r;
    logic        in_ready, out_valid, out_reg_w, out_mem2r;
    logic [9:0]  out_dm_addr;
    logic [31:0] out_dm_out, out_wb_data;
    logic [4:0]  out_rd;
`ifdef WB_PIPE_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif

    always #5 clk = ~clk;

    wb_pipe_reg dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .dm_addr     (dm_addr),
        .alu_res     (alu_res),
        .dm_out      (dm_out),
        .rd          (rd),
        .reg_w       (reg_w),
        .mem2r       (mem2r),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_dm_addr (out_dm_addr),
        .out_dm_out  (out_dm_out),
        .out_rd      (out_rd),
        .out_reg_w   (out_reg_w),
        .out_mem2r   (out_mem2r),
        .out_wb_data (out_wb_data)
`ifdef WB_PIPE_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    typedef struct {
        logic [9:0]  a;
        logic [31:0] alu;
        logic [31:0] dm;
        logic [4:0]  rd;
        logic        rw;
        logic        m2;
    } ent_t;

    ent_t mq[$];
    ent_t last;
    int   stall_m, bubble_m;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        bit v;
        v = mq.size() > 0;
        chk("in_ready", in_ready, mq.size() < 2);
        chk("out_valid", out_valid, v);
        chk("out_reg_w", out_reg_w, v ? last.rw : 1'b0);
        chk("out_wb_data", out_wb_data, v ? (last.m2 ? last.dm : last.alu) : 32'd0);
        chk("out_dm_addr", out_dm_addr, last.a);
        chk("out_dm_out", out_dm_out, last.dm);
        chk("out_rd", out_rd, last.rd);
        chk("out_mem2r", out_mem2r, last.m2);
`ifdef WB_PIPE_PERF_EN
        chk("stall_cnt", stall_cnt, stall_m);
        chk("bubble_cnt", bubble_cnt, bubble_m);
`endif
    endtask

    // Advance one clock: model is updated from the inputs seen at the edge, then outputs are compared.
    task automatic cycle();
        int   sz;
        bit   acc, pop;
        ent_t cur;
        sz  = mq.size();
        acc = in_valid && (sz < 2);
        pop = (sz > 0) && out_ready;
        cur.a = dm_addr; cur.alu = alu_res; cur.dm = dm_out;
        cur.rd = rd; cur.rw = reg_w; cur.m2 = mem2r;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            last = '{default: '0};
            stall_m  = 0;
            bubble_m = 0;
        end else begin
            if (flush) begin
                stall_m  = 0;
                bubble_m = 0;
            end else begin
                if (sz > 0 && !out_ready) stall_m++;
                if (sz == 0) bubble_m++;
            end
            if (pop) void'(mq.pop_front());
            if (flush) mq.delete();
            else if (acc) mq.push_back(cur);
        end
        if (mq.size() > 0) last = mq[0];
        #1;
        check_all();
    endtask

    task automatic set_in(input logic [9:0] a, input logic [31:0] alu, input logic [31:0] dm,
                          input logic [4:0] r, input logic rw, input logic m2);
        dm_addr = a; alu_res = alu; dm_out = dm; rd = r; reg_w = rw; mem2r = m2;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
        set_in(10'h5, 32'h1234, 32'h5678, 5'd7, 1'b1, 1'b0);
        last = '{default: '0};
        stall_m = 0; bubble_m = 0;

        // Reset held two cycles with in_valid high
        cycle(); cycle();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_wb_data", out_wb_data, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        cycle();
        chk("rst_in_ready", in_ready, 1'b1);

        // Streaming, never stalls
        out_ready = 1'b1; in_valid = 1'b1;
        set_in(10'h40, 32'h11, 32'hAA, 5'd3, 1'b1, 1'b0);
        cycle();
        chk("stream_alu", out_wb_data, 32'h11);
        set_in(10'h41, 32'h11, 32'hAA, 5'd3, 1'b1, 1'b1);
        cycle();
        chk("stream_mem", out_wb_data, 32'hAA);
        chk("stream_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        cycle();

        // Backpressure: A then B, head holds A
        out_ready = 1'b0; in_valid = 1'b1;
        set_in(10'h1A, 32'hA0A0, 32'hA1A1, 5'd10, 1'b1, 1'b0);
        cycle();
        set_in(10'h1B, 32'hB0B0, 32'hB1B1, 5'd11, 1'b1, 1'b1);
        cycle();
        in_valid = 1'b0;
        chk("bp_in_ready", in_ready, 1'b0);
        cycle(); cycle();
        chk("bp_head_a", out_wb_data, 32'hA0A0);
        out_ready = 1'b1;
        cycle();
        chk("bp_head_b", out_wb_data, 32'hB1B1);
        chk("bp_ready_back", in_ready, 1'b1);
        cycle();

        // Flush in TWO with a colliding input
        out_ready = 1'b0; in_valid = 1'b1;
        set_in(10'h2, 32'h2, 32'h22, 5'd2, 1'b1, 1'b0); cycle();
        set_in(10'h3, 32'h3, 32'h33, 5'd3, 1'b1, 1'b0); cycle();
        set_in(10'h4, 32'h4, 32'h44, 5'd4, 1'b1, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_reg_w", out_reg_w, 1'b0);
        out_ready = 1'b1;
        cycle(); cycle();

        // Bubble: three idle cycles after a counter-clearing flush
        flush = 1'b1; cycle(); flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bubble_reg_w", out_reg_w, 1'b0);
        end
`ifdef WB_PIPE_PERF_EN
        chk("bubble_cnt3", bubble_cnt, 32'd3);
`endif

        // Stall: one held entry, five stalled cycles, then flush
        flush = 1'b1; cycle(); flush = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        set_in(10'h77, 32'h77, 32'h7777, 5'd17, 1'b1, 1'b1);
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
`ifdef WB_PIPE_PERF_EN
        chk("stall_cnt5", stall_cnt, 32'd5);
`endif
        flush = 1'b1; cycle(); flush = 1'b0;
`ifdef WB_PIPE_PERF_EN
        chk("stall_cnt_clr", stall_cnt, 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 9) < 7);
            set_in(10'($urandom), $urandom, $urandom, 5'($urandom),
                   1'($urandom), 1'($urandom));
            cycle();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
